// File: rtl/uart_frame_tx.sv
// uart_frame_tx: frames an NBYTES-wide word as optional header, payload
// (least significant byte first) and optional additive checksum. Each byte
// is handed to the byte-level UART transmitter with a request/done handshake.
//
//   state | meaning
//   IDLE  | waiting for send; outputs quiet, sta = 0
//   REQ   | uart_send high, send_data = byte[idx], waiting for uart_send_done
//   GAP   | one-cycle low gap between requests; decides next byte or DONE
//   DONE  | send_done pulse, returning to IDLE
module uart_frame_tx #(
    parameter int          NBYTES  = 40,
    parameter int          HDR_EN  = 0,
    parameter logic [7:0]  HEADER  = 8'hAA,
    parameter int          CSUM_EN = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  send,
    input  logic                  abort,
    input  logic [8*NBYTES-1:0]   data,
    output logic                  busy,
    output logic                  send_done,
    output logic                  uart_send,
    output logic [7:0]            send_data,
    input  logic                  uart_send_done,
    output logic [7:0]            sta
);

    localparam int         FRAME_LEN = HDR_EN + NBYTES + CSUM_EN;
    localparam logic [7:0] LAST_IDX  = 8'(FRAME_LEN);
    localparam logic [7:0] NB8       = 8'(NBYTES);
    localparam logic [7:0] HDR8      = 8'(HDR_EN);

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    state_t              state;
    logic [8*NBYTES-1:0] shadow;
    logic [7:0]          idx;
    logic [7:0]          sum;

    logic [7:0]          pay_idx;
    logic                is_hdr;
    logic                is_payload;
    logic [7:0]          next_byte;
    logic [7:0]          first_byte;

    // Decode what frame position idx refers to and the byte it carries.
    always_comb begin
        pay_idx    = idx - HDR8;
        is_hdr     = (HDR_EN != 0) && (idx == 8'd0);
        is_payload = !is_hdr && (pay_idx < NB8);
        next_byte  = 8'h00;
        if (is_hdr) begin
            next_byte = HEADER;
        end else if (is_payload) begin
            next_byte = shadow[int'(pay_idx)*8 +: 8];
        end else begin
            next_byte = sum;
        end
        // Shadow is not loaded yet on the start edge, so byte 0 comes from data.
        first_byte = (HDR_EN != 0) ? HEADER : data[7:0];
    end

    // Frame sequencer with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shadow    <= '0;
            idx       <= 8'd0;
            sum       <= 8'd0;
            busy      <= 1'b0;
            send_done <= 1'b0;
            uart_send <= 1'b0;
            send_data <= 8'h00;
            sta       <= 8'd0;
        end else begin
            send_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (send) begin
                        shadow    <= data;
                        idx       <= 8'd0;
                        sum       <= 8'd0;
                        busy      <= 1'b1;
                        uart_send <= 1'b1;
                        send_data <= first_byte;
                        sta       <= 8'd0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        uart_send <= 1'b0;
                        sta       <= 8'd0;
                    end else if (uart_send_done) begin
                        // send_data still holds byte[idx], so it feeds the sum.
                        if (is_payload) begin
                            sum <= sum + send_data;
                        end
                        idx       <= idx + 8'd1;
                        uart_send <= 1'b0;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        sta   <= 8'd0;
                    end else if (idx == LAST_IDX) begin
                        send_done <= 1'b1;
                        state     <= DONE;
                    end else begin
                        uart_send <= 1'b1;
                        send_data <= next_byte;
                        sta       <= idx;
                        state     <= REQ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sta   <= 8'd0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    uart_send <= 1'b0;
                    sta       <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Testbench for uart_frame_tx: three configurations (plain 4-byte, header +
// checksum 3-byte, plain 2-byte) driven by a transmitter stand-in and checked
// against a byte-list reference built directly from the framing rules.
module tb_uart_frame_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_v  [3];
    logic        abort_v [3];
    logic        ack_v   [3];
    logic [31:0] data_v  [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        us_v    [3];
    logic [7:0]  sd_v    [3];
    logic [7:0]  sta_v   [3];

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt [3] = '{0, 0, 0};

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    always #5 clk = ~clk;

    uart_frame_tx #(.NBYTES(4), .HDR_EN(0), .HEADER(8'hAA), .CSUM_EN(0)) u0 (
        .clk(clk), .rst(rst), .send(send_v[0]), .abort(abort_v[0]),
        .data(data_v[0]), .busy(busy_v[0]), .send_done(done_v[0]),
        .uart_send(us_v[0]), .send_data(sd_v[0]),
        .uart_send_done(ack_v[0]), .sta(sta_v[0]));

    uart_frame_tx #(.NBYTES(3), .HDR_EN(1), .HEADER(8'hAA), .CSUM_EN(1)) u1 (
        .clk(clk), .rst(rst), .send(send_v[1]), .abort(abort_v[1]),
        .data(data_v[1][23:0]), .busy(busy_v[1]), .send_done(done_v[1]),
        .uart_send(us_v[1]), .send_data(sd_v[1]),
        .uart_send_done(ack_v[1]), .sta(sta_v[1]));

    uart_frame_tx #(.NBYTES(2), .HDR_EN(0), .HEADER(8'hAA), .CSUM_EN(0)) u2 (
        .clk(clk), .rst(rst), .send(send_v[2]), .abort(abort_v[2]),
        .data(data_v[2][15:0]), .busy(busy_v[2]), .send_done(done_v[2]),
        .uart_send(us_v[2]), .send_data(sd_v[2]),
        .uart_send_done(ack_v[2]), .sta(sta_v[2]));

    // Count send_done pulses per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) done_cnt[i]++;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          s;
        logic [31:0] d;
        int          dly;
        int          exp_len;
        logic [7:0]  exp_first;
        logic [7:0]  exp_last;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the byte list a frame must carry, from the framing rules.
    task automatic build_exp(input int s, input logic [31:0] d);
        int         nb;
        logic [8:0] total;
        exp_q.delete();
        total = 9'd0;
        nb = (s == 0) ? 4 : (s == 1) ? 3 : 2;
        if (s == 1) exp_q.push_back(8'hAA);
        for (int i = 0; i < nb; i++) begin
            exp_q.push_back(d[8*i +: 8]);
            total = total + {1'b0, d[8*i +: 8]};
        end
        if (s == 1) exp_q.push_back(total[7:0]);
    endtask

    task automatic start_frame(input int s, input logic [31:0] d);
        build_exp(s, d);
        data_v[s] = d;
        send_v[s] = 1'b1;
        tick();
        send_v[s] = 1'b0;
        chk("start_busy", {31'd0, busy_v[s]}, 32'd1);
        chk("start_req", {31'd0, us_v[s]}, 32'd1);
    endtask

    // Act as the transmitter for one frame already started; check every byte.
    task automatic serve_frame(input int s, input int dly, input int abort_k, input bit poke);
        int d0;
        int c;
        d0 = done_cnt[s];
        obs_q.delete();
        for (int k = 0; k < exp_q.size(); k++) begin
            c = 0;
            while (!us_v[s] && c < 40) begin
                tick();
                c++;
            end
            if (!us_v[s]) begin
                n_cmp++;
                n_bad++;
                $display("FAIL req_timeout: no request for byte %0d, got 0 expected 1", k);
                return;
            end
            obs_q.push_back(sd_v[s]);
            chk("byte", {24'd0, sd_v[s]}, {24'd0, exp_q[k]});
            chk("sta", {24'd0, sta_v[s]}, k);
            chk("busy_frame", {31'd0, busy_v[s]}, 32'd1);
            for (int w = 0; w < dly; w++) begin
                tick();
                chk("req_hold", {31'd0, us_v[s]}, 32'd1);
                chk("data_hold", {24'd0, sd_v[s]}, {24'd0, exp_q[k]});
            end
            ack_v[s] = 1'b1;
            if (k == abort_k) abort_v[s] = 1'b1;
            if (poke && k == 1) begin
                data_v[s] = ~data_v[s];
                send_v[s] = 1'b1;
            end
            tick();
            ack_v[s]   = 1'b0;
            abort_v[s] = 1'b0;
            if (poke && k == 1) send_v[s] = 1'b0;
            chk("req_drop", {31'd0, us_v[s]}, 32'd0);
            if (k == abort_k) begin
                chk("abort_busy", {31'd0, busy_v[s]}, 32'd0);
                chk("abort_sta", {24'd0, sta_v[s]}, 32'd0);
                repeat (4) tick();
                chk("abort_no_done", done_cnt[s] - d0, 32'd0);
                chk("abort_idle", {31'd0, us_v[s]}, 32'd0);
                return;
            end
        end
        chk("gap_no_done", {31'd0, done_v[s]}, 32'd0);
        tick();
        chk("done_pulse", {31'd0, done_v[s]}, 32'd1);
        chk("busy_in_done", {31'd0, busy_v[s]}, 32'd1);
        tick();
        chk("done_end", {31'd0, done_v[s]}, 32'd0);
        chk("busy_end", {31'd0, busy_v[s]}, 32'd0);
        chk("done_count", done_cnt[s] - d0, 32'd1);
    endtask

    initial begin
        vec_t vecs [4];
        int          s;
        int          dly;
        logic [31:0] d;

        vecs[0] = '{0, 32'h44332211, 5, 4, 8'h11, 8'h44};
        vecs[1] = '{1, 32'h00F02010, 3, 5, 8'hAA, 8'h20};
        vecs[2] = '{2, 32'h0000BBAA, 2, 2, 8'hAA, 8'hBB};
        vecs[3] = '{1, 32'h00FFFFFF, 1, 5, 8'hAA, 8'hFD};

        for (int i = 0; i < 3; i++) begin
            send_v[i]  = 1'b1;
            abort_v[i] = 1'b0;
            ack_v[i]   = 1'b0;
            data_v[i]  = 32'hFFFF_FFFF;
        end
        rst = 1'b0;

        // Reset held with send high: everything stays quiet.
        repeat (3) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                chk("rst_busy", {31'd0, busy_v[i]}, 32'd0);
                chk("rst_done", {31'd0, done_v[i]}, 32'd0);
                chk("rst_req", {31'd0, us_v[i]}, 32'd0);
                chk("rst_data", {24'd0, sd_v[i]}, 32'd0);
                chk("rst_sta", {24'd0, sta_v[i]}, 32'd0);
            end
        end
        for (int i = 0; i < 3; i++) send_v[i] = 1'b0;
        rst = 1'b1;
        repeat (2) tick();

        // Directed vectors.
        for (int v = 0; v < 4; v++) begin
            start_frame(vecs[v].s, vecs[v].d);
            serve_frame(vecs[v].s, vecs[v].dly, -1, 1'b0);
            chk("tbl_len", obs_q.size(), vecs[v].exp_len);
            if (obs_q.size() > 0) begin
                chk("tbl_first", {24'd0, obs_q[0]}, {24'd0, vecs[v].exp_first});
                chk("tbl_last", {24'd0, obs_q[obs_q.size()-1]}, {24'd0, vecs[v].exp_last});
            end
            tick();
        end

        // Data change and send pulse mid-frame are ignored.
        start_frame(0, 32'h44332211);
        serve_frame(0, 2, -1, 1'b1);
        repeat (5) tick();
        chk("poke_no_restart_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("poke_no_restart_req", {31'd0, us_v[0]}, 32'd0);

        // Abort together with the ack of byte 2, then a fresh frame from byte 0.
        start_frame(0, 32'hDEADBEEF);
        serve_frame(0, 1, 2, 1'b0);
        start_frame(0, 32'h44332211);
        serve_frame(0, 0, -1, 1'b0);

        // uart_send_done while idle is ignored.
        ack_v[0] = 1'b1;
        repeat (2) tick();
        ack_v[0] = 1'b0;
        chk("idle_ack_busy", {31'd0, busy_v[0]}, 32'd0);
        chk("idle_ack_req", {31'd0, us_v[0]}, 32'd0);

        // send held high: back-to-back frames.
        build_exp(2, 32'h0000BBAA);
        data_v[2] = 32'h0000BBAA;
        send_v[2] = 1'b1;
        tick();
        chk("b2b_start", {31'd0, us_v[2]}, 32'd1);
        serve_frame(2, 2, -1, 1'b0);
        tick();
        chk("b2b_restart_busy", {31'd0, busy_v[2]}, 32'd1);
        chk("b2b_restart_req", {31'd0, us_v[2]}, 32'd1);
        send_v[2] = 1'b0;
        serve_frame(2, 2, -1, 1'b0);
        repeat (4) tick();
        chk("b2b_stop", {31'd0, busy_v[2]}, 32'd0);

        // Reset asserted mid-frame clears outputs at once; nothing follows.
        start_frame(1, 32'h00123456);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, busy_v[1]}, 32'd0);
        chk("async_rst_req", {31'd0, us_v[1]}, 32'd0);
        chk("async_rst_data", {24'd0, sd_v[1]}, 32'd0);
        tick();
        rst = 1'b1;
        repeat (5) tick();
        chk("post_rst_req", {31'd0, us_v[1]}, 32'd0);
        chk("post_rst_busy", {31'd0, busy_v[1]}, 32'd0);

        // Randomized frames against the reference byte list.
        for (int r = 0; r < 24; r++) begin
            s   = $urandom_range(0, 2);
            d   = $urandom;
            dly = $urandom_range(0, 4);
            start_frame(s, d);
            serve_frame(s, dly, -1, 1'b0);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Parametrised UART frame serializer. Captures an NBYTES-wide data word on a one-cycle `send` request and streams it byte by byte, least significant byte first, to the byte-level UART transmitter. Each byte uses a request/done handshake. An optional header byte and an optional 8-bit additive checksum frame the payload. Sits between the application and the UART transmitter; supersedes the fixed 40-byte sender.

## Interface
- NBYTES, 40: payload bytes per frame; legal range 1..253.
- HDR_EN, 0: 1 = send HEADER before the payload.
- HEADER, 8'hAA: header byte value.
- CSUM_EN, 0: 1 = append the checksum byte after the payload.

Ports (clock and reset first):
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- send  in  1  start request; sampled only in IDLE.
- abort  in  1  synchronous abort; effective in any non-IDLE state.
- data  in  8*NBYTES  payload; byte k = data[8k+7:8k]; captured at start.
- busy  out  1  high from the cycle after start until return to IDLE.
- send_done  out  1  one-cycle pulse after the last byte's handshake completes.
- uart_send  out  1  level request to the UART transmitter.
- send_data  out  8  byte presented to the UART transmitter.
- uart_send_done  in  1  transmitter completion strobe (one cycle or longer).
- sta  out  8  index of the byte in flight, 0..L-1; 0 in IDLE.

## Operation
- Frame length L = HDR_EN + NBYTES + CSUM_EN.
- Byte order on the line: HEADER (if HDR_EN), payload bytes 0..NBYTES-1, then checksum (if CSUM_EN).
- Checksum = sum of the payload bytes mod 256. The header is excluded.
- State machine: IDLE, REQ, GAP, DONE.
  - IDLE:
    - If send = 1: capture data into the shadow register, idx <= 0, sum <= 0, go to REQ.
    - Otherwise stay in IDLE.
  - REQ:
    - uart_send = 1; send_data = byte[idx]; stay until uart_send_done = 1.
    - On that edge: sum += payload byte (payload bytes only), idx++, go to GAP.
  - GAP:
    - uart_send = 0 for exactly one cycle.
    - If idx == L: go to DONE. Otherwise go to REQ.
  - DONE: send_done = 1 for one cycle, then go to IDLE.
- abort = 1 in REQ, GAP or DONE: go to IDLE next edge, uart_send <= 0, no send_done pulse. abort has priority over uart_send_done in the same cycle.
- send while not in IDLE is ignored. Changes on data during a frame have no effect.
- send held high continuously: a new frame starts on the IDLE cycle that follows DONE.
- uart_send_done in IDLE, GAP or DONE is ignored.
- All outputs are registered.

## Timing
- Reset values: busy = 0, send_done = 0, uart_send = 0, send_data = 8'h00, sta = 0, state = IDLE, shadow register = 0.
- Reset asserted mid-frame: the reset values apply immediately (asynchronously). No further bytes are requested after reset is released.
- send sampled high at edge T:
  - uart_send and busy are high after T.
  - send_data holds byte 0 after T.
- send_data is stable for the whole time uart_send is high. It changes only on entry to REQ.
- uart_send_done sampled high at edge D: uart_send is low after D and high again after D+2, carrying the next byte.
- Per-byte overhead beyond the transmitter latency: 2 cycles (the handshake edge plus GAP).
- Last handshake at edge D:
  - GAP after D.
  - send_done high for the cycle after D+1.
  - busy low after D+2.
- Minimum frame duration: 3L+2 cycles, assuming uart_send_done arrives 1 cycle after each request.

## Test plan
- Reset: hold rst low for 3 cycles with send = 1 → all outputs 0, no uart_send.
- NBYTES=4, HDR_EN=0, CSUM_EN=0, data=32'h44332211, send pulse, transmitter acks 5 cycles after each request → send_data sequence 11,22,33,44; exactly one send_done, 2 cycles after the 4th ack; sta steps 0..3.
- NBYTES=3, HDR_EN=1, CSUM_EN=1, data=24'hF0_20_10 → bytes AA,10,20,F0,20 (checksum 0x120 mod 256 = 0x20); busy low after the final send_done.
- Change data and pulse send mid-frame (NBYTES=4) → the transmitted bytes match the originally captured word; no second frame starts; exactly one send_done.
- Assert abort in the same cycle as uart_send_done on byte 2 → uart_send low next cycle, return to IDLE, no send_done; a fresh send then starts again at byte 0.
- Hold send high across two frames (NBYTES=2, data=16'hBBAA), with 2-cycle acks → the AA,BB frame repeats back-to-back; uart_send is low at least one cycle between bytes; send_done pulses once per frame.
